uart_rx_ctrl: RTL
=================

Name: uart_rx_ctrl

Overview:
Sequencing FSM for the UART receive path. It detects the start bit and runs the oversampling edge counter and the bit counter. It issues per-bit strobes to the deserializer, the start/parity/stop checkers and the parity-bit capture, then combines the checker results into a single frame-done verdict. It sits between the synchronized rx line and the Rx datapath checkers, including the stop-bit checker.

Parameters:
DATA_WIDTH, 8, data bits per frame
PRESCALE_W, 6, width of prescale input and edge counter

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
rx_in  in  1  synchronized serial line, idle high
prescale  in  PRESCALE_W  clocks per bit, legal 4..2^PRESCALE_W-1
par_en  in  1  frame carries a parity bit
par_error  in  1  combinational result from parity checker
stop_error  in  1  combinational result from stop checker
strt_chk_en  out  1  start-bit check strobe
deser_en  out  1  data-bit sample strobe
bit_idx  out  clog2(DATA_WIDTH)  index of bit being sampled
par_load  out  1  parity-bit capture strobe
par_chk_en  out  1  parity checker evaluate enable
stop_chk_load  out  1  stop-bit capture strobe
stop_chk_en  out  1  stop checker evaluate enable
busy  out  1  state != IDLE
data_valid  out  1  one-cycle pulse, frame good
parity_err  out  1  one-cycle pulse, frame had a parity error
framing_err  out  1  one-cycle pulse, frame had a stop error
strt_glitch  out  1  one-cycle pulse, false start rejected

Behaviour:
- Reset (synchronous, reset=1 at clk edge) sets: state IDLE; edge_cnt=0; bit_cnt=0; latched prescale/par_en=0; data_valid, parity_err, framing_err and strt_glitch = 0.
- All strobes decode from the state and counter registers, so every strobe is 0 while in IDLE.
- half = latched_prescale >> 1.
- prescale and par_en are latched only on the IDLE->START transition. Changes during a frame are ignored.
- edge_cnt increments every cycle outside IDLE and wraps from prescale-1 to 0. A wrap is the bit boundary.

State machine:
- IDLE: rx_in==0 -> START. That detect cycle is counted as edge_cnt 0 of the start bit.
- START:
  - At edge_cnt==half: strt_chk_en=1. If rx_in==1 there, the next state is IDLE and strt_glitch pulses in the following cycle.
  - At edge_cnt==prescale-1: -> DATA, bit_cnt=0.
- DATA:
  - At edge_cnt==half: deser_en=1, with bit_idx=bit_cnt (LSB first).
  - At the bit boundary: if bit_cnt==DATA_WIDTH-1, go to PARITY when par_en is latched, else STOP. Otherwise bit_cnt++.
- PARITY: par_load=1 at edge_cnt==half. At the bit boundary -> STOP.
- STOP:
  - At edge_cnt==half: stop_chk_load=1.
  - At edge_cnt==half+1: stop_chk_en=1, and par_chk_en=latched par_en. The FSM samples stop_error and (par_error AND par_en) that same cycle, then goes to IDLE next cycle.
- Verdict, registered, one cycle after the evaluate cycle:
  - data_valid = no error.
  - parity_err = parity error.
  - framing_err = stop error.
  - Both error pulses may assert together. data_valid is never high together with either error.
- Receiver is re-armed (IDLE) from half+2 of the stop bit. A new falling edge after that point is accepted.
- Reset mid-frame aborts the frame with no verdict pulse. The first cycle after reset is IDLE.
- Only one strobe is active in any cycle, except stop_chk_en with par_chk_en.
- Verdict latency from start detect (T0), no parity: data_valid at T0 + (DATA_WIDTH+1)*prescale + half + 2. With parity, add prescale.

Test Plan:
1. prescale=8, par_en=0, frame 0xA5 with stop=1, start detect at T0 -> deser_en at T0+12+8i (i=0..7); bit_idx=i; stop_chk_load at T0+76; stop_chk_en at T0+77; data_valid at T0+78; busy low from T0+78.
2. prescale=8, par_en=1, par_error=1 at the evaluate cycle -> par_load at T0+76; stop_chk_load at T0+84; parity_err pulse at T0+86; data_valid stays 0.
3. prescale=8, rx_in low for 2 cycles only -> strt_chk_en at T0+4; strt_glitch at T0+5; state IDLE at T0+5; no deser_en.
4. stop bit driven 0 (stop_error=1), par_en=0 -> framing_err at T0+78; data_valid=0.
5. reset asserted at T0+40 mid-DATA -> next cycle busy=0; no verdict pulses. A frame started afterwards completes normally.
6. Back-to-back frames: second start edge at T0+78, and prescale changed to 16 during frame 1 -> frame 1 uses 8, frame 2 uses 16; both give data_valid.

Source files
------------

// File: rtl/uart_rx_ctrl.sv
// UART receive sequencer: start detect, oversampling edge/bit counters,
// per-bit strobes to the Rx datapath checkers and a registered frame verdict.
module uart_rx_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int PRESCALE_W = 6,
  localparam int IDX_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  rx_in,
  input  logic [PRESCALE_W-1:0] prescale,
  input  logic                  par_en,
  input  logic                  par_error,
  input  logic                  stop_error,
  output logic                  strt_chk_en,
  output logic                  deser_en,
  output logic [IDX_W-1:0]      bit_idx,
  output logic                  par_load,
  output logic                  par_chk_en,
  output logic                  stop_chk_load,
  output logic                  stop_chk_en,
  output logic                  busy,
  output logic                  data_valid,
  output logic                  parity_err,
  output logic                  framing_err,
  output logic                  strt_glitch
);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  localparam logic [IDX_W-1:0] LAST_BIT = IDX_W'(DATA_WIDTH - 1);

  state_t                state, state_nx;
  logic [PRESCALE_W-1:0] edge_cnt, edge_nx, pre_q, half;
  logic [IDX_W-1:0]      bit_cnt, bit_nx;
  logic                  par_q, mid, last, eval_nx, glitch_nx;

  assign half    = pre_q >> 1;
  assign mid     = (edge_cnt == half);
  assign last    = (edge_cnt == pre_q - 1'b1);
  assign busy    = (state != IDLE);
  assign bit_idx = bit_cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      edge_cnt    <= '0;
      bit_cnt     <= '0;
      pre_q       <= '0;
      par_q       <= 1'b0;
      data_valid  <= 1'b0;
      parity_err  <= 1'b0;
      framing_err <= 1'b0;
      strt_glitch <= 1'b0;
    end else begin
      state    <= state_nx;
      edge_cnt <= edge_nx;
      bit_cnt  <= bit_nx;
      // Frame parameters are frozen at start detect.
      if (state == IDLE && !rx_in) begin
        pre_q <= prescale;
        par_q <= par_en;
      end
      data_valid  <= eval_nx && !stop_error && !(par_error && par_q);
      parity_err  <= eval_nx && par_error && par_q;
      framing_err <= eval_nx && stop_error;
      strt_glitch <= glitch_nx;
    end
  end

  always_comb begin
    state_nx      = state;
    edge_nx       = last ? '0 : edge_cnt + 1'b1;
    bit_nx        = bit_cnt;
    strt_chk_en   = 1'b0;
    deser_en      = 1'b0;
    par_load      = 1'b0;
    par_chk_en    = 1'b0;
    stop_chk_load = 1'b0;
    stop_chk_en   = 1'b0;
    eval_nx       = 1'b0;
    glitch_nx     = 1'b0;
    case (state)
      IDLE: begin
        // The detect cycle itself is edge 0 of the start bit.
        edge_nx = '0;
        if (!rx_in) begin
          state_nx = START;
          edge_nx  = PRESCALE_W'(1);
        end
      end
      START: begin
        if (mid) begin
          strt_chk_en = 1'b1;
          if (rx_in) begin
            state_nx  = IDLE;
            edge_nx   = '0;
            glitch_nx = 1'b1;
          end
        end else if (last) begin
          state_nx = DATA;
          bit_nx   = '0;
        end
      end
      DATA: begin
        deser_en = mid;
        if (last) begin
          if (bit_cnt == LAST_BIT) state_nx = par_q ? PARITY : STOP;
          else                     bit_nx   = bit_cnt + 1'b1;
        end
      end
      PARITY: begin
        par_load = mid;
        if (last) state_nx = STOP;
      end
      STOP: begin
        stop_chk_load = mid;
        // Evaluate one edge after capture, then re-arm without waiting for the bit end.
        if (edge_cnt == half + 1'b1) begin
          stop_chk_en = 1'b1;
          par_chk_en  = par_q;
          eval_nx     = 1'b1;
          state_nx    = IDLE;
          edge_nx     = '0;
        end
      end
      default: begin
        state_nx = IDLE;
        edge_nx  = '0;
      end
    endcase
  end

endmodule
